game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_timer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_game_timer_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl
// Sequencing controller for a BCD countdown timer built from a chain of
// loadable digit counters. It strobes a preset load into the chain, paces
// decrement requests to the least-significant digit with a prescaler, and
// supports pause/resume and expiry detection.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset; waits for a preset load request
// LOAD    | reconfig held high for LOAD_CYCLES cycles so the digits take the preset
// ARMED   | preset loaded; waits for start
// RUN     | prescaler counting; a tick is issued every TICK_DIV cycles
// PAUSE   | prescaler frozen; pause_tgl resumes with the same tick phase
// EXPIRED | count reached zero; held until the next load request or reset

module game_timer_ctrl #(
   parameter int TICK_DIV    = 50000000,
   parameter int LOAD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_req,
   input  logic        start,
   input  logic        pause_tgl,
   input  logic [15:0] digits_in,
   output logic        reconfig,
   output logic        tick,
   output logic        running,
   output logic        timeout,
   output logic        warn,
   output logic [2:0]  state
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [LW-1:0] LOAD_INIT  = LW'(LOAD_CYCLES - 1);
   localparam logic [LW-1:0] LOAD_ONE   = LW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ARMED   = 3'd2,
      S_RUN     = 3'd3,
      S_PAUSE   = 3'd4,
      S_EXPIRED = 3'd5
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_presc;
   logic [LW-1:0]   r_load_cnt;
   logic            r_reconfig;
   logic            r_running;
   logic            r_timeout;

   state_t          w_state_nxt;
   logic            w_digits_zero;
   logic            w_presc_last;
   logic            w_load_entry;
   logic            w_run_entry;
   logic            w_tick;
   logic            w_warn;

   assign w_digits_zero = (digits_in == 16'h0000);
   assign w_presc_last  = (r_presc == PRESC_LAST);
   assign w_load_entry  = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
   assign w_run_entry   = (r_state == S_ARMED) && (w_state_nxt == S_RUN);

   // Next-state selection: a load request outranks everything except an
   // ongoing load; in RUN the expiry check outranks pause.
   always_comb begin
      w_state_nxt = r_state;
      if (load_req && (r_state != S_LOAD)) begin
         w_state_nxt = S_LOAD;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_IDLE;
            end
            S_LOAD: begin
               if (r_load_cnt == '0) begin
                  w_state_nxt = S_ARMED;
               end
            end
            S_ARMED: begin
               if (start) begin
                  w_state_nxt = w_digits_zero ? S_EXPIRED : S_RUN;
               end
            end
            S_RUN: begin
               if (w_digits_zero) begin
                  w_state_nxt = S_EXPIRED;
               end else if (pause_tgl) begin
                  w_state_nxt = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (pause_tgl) begin
                  w_state_nxt = S_RUN;
               end
            end
            S_EXPIRED: begin
               w_state_nxt = S_EXPIRED;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State register with outputs registered from the next state so they
   // always line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_reconfig <= 1'b0;
         r_running  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_reconfig <= (w_state_nxt == S_LOAD);
         r_running  <= (w_state_nxt == S_RUN);
         r_timeout  <= (w_state_nxt == S_EXPIRED);
      end
   end

   // Load hold timer: down-counter preset on LOAD entry, LOAD ends at zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_load_cnt <= '0;
      end else if (w_load_entry) begin
         r_load_cnt <= LOAD_INIT;
      end else if ((r_state == S_LOAD) && (r_load_cnt != '0)) begin
         r_load_cnt <= r_load_cnt - LOAD_ONE;
      end
   end

   // Tick prescaler: cleared when a countdown starts, advances only in RUN,
   // and simply holds otherwise so a pause keeps the tick phase.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_presc <= '0;
      end else if (w_run_entry) begin
         r_presc <= '0;
      end else if (r_state == S_RUN) begin
         if (w_presc_last) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PRESC_ONE;
         end
      end
   end

   // A zero count suppresses the tick in the cycle that detects expiry.
   assign w_tick = (r_state == S_RUN) && w_presc_last && !w_digits_zero;
   assign w_warn = ((r_state == S_RUN) || (r_state == S_PAUSE)) &&
                   (digits_in < 16'h0010);

   assign reconfig = r_reconfig;
   assign running  = r_running;
   assign timeout  = r_timeout;
   assign state    = r_state;
   assign tick     = w_tick;
   assign warn     = w_warn;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl with TICK_DIV=4, LOAD_CYCLES=2.
// Directed vector table, a few hand-written corner sequences, then random
// traffic against a behavioural model that counts RUN cycles since start.

module tb_game_timer_ctrl;

   localparam int TD = 4;
   localparam int LC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_req;
   logic        start;
   logic        pause_tgl;
   logic [15:0] digits_in;
   logic        reconfig;
   logic        tick;
   logic        running;
   logic        timeout;
   logic        warn;
   logic [2:0]  state;

   always #5 clk = ~clk;

   game_timer_ctrl #(.TICK_DIV(TD), .LOAD_CYCLES(LC)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_req  (load_req),
      .start     (start),
      .pause_tgl (pause_tgl),
      .digits_in (digits_in),
      .reconfig  (reconfig),
      .tick      (tick),
      .running   (running),
      .timeout   (timeout),
      .warn      (warn),
      .state     (state)
   );

   int n_vec     = 0;
   int n_miscmp  = 0;

   // behavioural model: state code, RUN cycles since start, load cycles left
   int m_state   = 0;
   int m_run_n   = 0;
   int m_load_left = 0;

   typedef struct {
      logic        l;
      logic        s;
      logic        p;
      logic [15:0] d;
      logic [2:0]  st;
      logic        tk;
      logic        rc;
      logic        rn;
      logic        to;
      logic        wn;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic l, input logic s, input logic p, input logic [15:0] d,
                      input logic [2:0] st, input logic tk, input logic rc,
                      input logic rn, input logic to, input logic wn);
      vec_t v;
      v.l = l; v.s = s; v.p = p; v.d = d;
      v.st = st; v.tk = tk; v.rc = rc; v.rn = rn; v.to = to; v.wn = wn;
      tbl.push_back(v);
   endtask

   // {state[2:0], tick, reconfig, running, timeout, warn}
   function automatic logic [7:0] model_out(input logic [15:0] d);
      logic [2:0] st;
      logic       tk;
      logic       wn;
      st = 3'(m_state);
      tk = (m_state == 3) && ((m_run_n % TD) == TD - 1) && (d != 16'h0000);
      wn = ((m_state == 3) || (m_state == 4)) && (d < 16'h0010);
      return {st, tk, (m_state == 1), (m_state == 3), (m_state == 5), wn};
   endfunction

   task automatic model_step();
      if (!rst) begin
         m_state = 0; m_run_n = 0; m_load_left = 0;
      end else if (load_req && m_state != 1) begin
         m_state = 1; m_load_left = LC;
      end else begin
         case (m_state)
            1: begin
               m_load_left--;
               if (m_load_left == 0) m_state = 2;
            end
            2: if (start) begin
               if (digits_in == 16'h0000) m_state = 5;
               else begin m_state = 3; m_run_n = 0; end
            end
            3: begin
               m_run_n++;
               if (digits_in == 16'h0000) m_state = 5;
               else if (pause_tgl) m_state = 4;
            end
            4: if (pause_tgl) m_state = 3;
            default: ;
         endcase
      end
   endtask

   task automatic drive(input logic r, input logic l, input logic s, input logic p,
                        input logic [15:0] d);
      rst = r; load_req = l; start = s; pause_tgl = p; digits_in = d;
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic compare(input string name, input logic [7:0] exp);
      logic [7:0] act;
      act = {state, tick, reconfig, running, timeout, warn};
      n_vec++;
      if (act !== exp) begin
         n_miscmp++;
         $display("FAIL %s: state=%0d tick=%b reconfig=%b running=%b timeout=%b warn=%b, expected state=%0d tick=%b reconfig=%b running=%b timeout=%b warn=%b",
                  name, act[7:5], act[4], act[3], act[2], act[1], act[0],
                  exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // drive one cycle, check against the model, then clock it
   task automatic mstep(input logic r, input logic l, input logic s, input logic p,
                        input logic [15:0] d, input string name);
      drive(r, l, s, p, d);
      #1;
      compare(name, model_out(d));
      advance();
   endtask

   initial begin
      logic [7:0]  e;
      logic [15:0] chain_d;

      // table: l s p digits | state tick reconfig running timeout warn
      add(0,0,0,16'd3,    3'd0,0,0,0,0,0);
      add(0,1,0,16'd3,    3'd0,0,0,0,0,0);
      add(0,0,1,16'd3,    3'd0,0,0,0,0,0);
      add(1,0,0,16'd3,    3'd0,0,0,0,0,0);
      add(1,0,0,16'd3,    3'd1,0,1,0,0,0);
      add(0,0,0,16'd3,    3'd1,0,1,0,0,0);
      add(0,0,0,16'd3,    3'd2,0,0,0,0,0);
      add(0,1,0,16'd3,    3'd2,0,0,0,0,0);
      add(0,0,0,16'd3,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd3,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd3,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd3,    3'd3,1,0,1,0,1);
      add(0,0,0,16'd2,    3'd3,0,0,1,0,1);
      add(0,0,0,16'h0010, 3'd3,0,0,1,0,0);
      add(0,0,0,16'h0009, 3'd3,0,0,1,0,1);
      add(0,0,0,16'd2,    3'd3,1,0,1,0,1);
      add(0,0,0,16'd1,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd1,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd1,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd1,    3'd3,1,0,1,0,1);
      add(0,0,0,16'd0,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd0,    3'd5,0,0,0,1,0);
      add(0,1,0,16'd0,    3'd5,0,0,0,1,0);
      add(0,0,1,16'd0,    3'd5,0,0,0,1,0);
      add(0,0,0,16'd5,    3'd5,0,0,0,1,0);
      add(1,0,0,16'd5,    3'd5,0,0,0,1,0);
      add(0,0,0,16'd5,    3'd1,0,1,0,0,0);
      add(0,0,0,16'd0,    3'd1,0,1,0,0,0);
      add(0,1,0,16'd0,    3'd2,0,0,0,0,0);
      add(0,0,0,16'd0,    3'd5,0,0,0,1,0);
      add(1,0,0,16'd0,    3'd5,0,0,0,1,0);
      add(0,0,0,16'd7,    3'd1,0,1,0,0,0);
      add(0,0,0,16'd7,    3'd1,0,1,0,0,0);
      add(0,1,0,16'd7,    3'd2,0,0,0,0,0);
      add(0,0,0,16'd7,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd7,    3'd3,0,0,1,0,1);
      add(1,0,1,16'd7,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd7,    3'd1,0,1,0,0,0);
      add(0,0,0,16'd7,    3'd1,0,1,0,0,0);
      add(0,1,0,16'd9,    3'd2,0,0,0,0,0);
      add(0,0,0,16'd9,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd9,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd9,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd0,    3'd3,0,0,1,0,1);
      add(0,0,0,16'd0,    3'd5,0,0,0,1,0);

      drive(0, 0, 0, 0, 16'd0);
      advance();
      advance();

      for (int i = 0; i < tbl.size(); i++) begin
         drive(1, tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].d);
         #1;
         compare($sformatf("vec%0d", i),
                 {tbl[i].st, tbl[i].tk, tbl[i].rc, tbl[i].rn, tbl[i].to, tbl[i].wn});
         advance();
      end

      // pause after two RUN cycles, hold ten cycles, resume: tick on the
      // second RUN cycle after resume
      mstep(1, 1, 0, 0, 16'd5, "pause_load");
      mstep(1, 0, 0, 0, 16'd5, "pause_load1");
      mstep(1, 0, 0, 0, 16'd5, "pause_load2");
      mstep(1, 0, 1, 0, 16'd5, "pause_start");
      mstep(1, 0, 0, 0, 16'd5, "pause_run0");
      mstep(1, 0, 0, 1, 16'd5, "pause_run1");
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 0, 0, 16'd5);
         #1;
         compare($sformatf("pause_hold%0d", i), {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
         advance();
      end
      mstep(1, 0, 0, 1, 16'd5, "pause_resume");
      drive(1, 0, 0, 0, 16'd5);
      #1;
      compare("resume_r0", {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
      advance();
      #1;
      compare("resume_r1_tick", {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
      advance();

      // reset while the prescaler sits at its last value in RUN
      mstep(1, 0, 0, 0, 16'd5, "rstrun_a");
      mstep(1, 0, 0, 0, 16'd5, "rstrun_b");
      mstep(1, 0, 0, 0, 16'd5, "rstrun_c");
      mstep(0, 0, 0, 0, 16'd5, "rstrun_assert");
      drive(1, 0, 0, 0, 16'd5);
      #1;
      compare("reset_run", 8'h00);
      advance();

      // reset in the middle of LOAD
      mstep(1, 1, 0, 0, 16'd5, "rstload_req");
      mstep(0, 0, 0, 0, 16'd5, "rstload_assert");
      drive(1, 0, 0, 0, 16'd5);
      #1;
      compare("reset_load", 8'h00);
      advance();

      // random traffic; digits follow a simple chain model that the bench
      // decrements on each expected tick
      chain_d = 16'd6;
      for (int i = 0; i < 3000; i++) begin
         logic r, l, s, p;
         r = ($urandom_range(0, 99) != 0);
         l = ($urandom_range(0, 29) == 0);
         s = ($urandom_range(0, 5) == 0);
         p = ($urandom_range(0, 9) == 0);
         if (l) chain_d = 16'($urandom_range(0, 12));
         if ($urandom_range(0, 39) == 0) chain_d = 16'($urandom_range(0, 40));
         e = model_out(chain_d);
         mstep(r, l, s, p, chain_d, "random");
         if (e[4] && chain_d != 16'd0) chain_d = chain_d - 16'd1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
